// File: rtl/serial_a_paralelo_pkg.sv
// Shared definitions for the receive-side serial-to-parallel front end.
package serial_pkg;

    localparam logic [7:0]  COM_CHAR       = 8'hBC;
    localparam int unsigned SYNC_COUNT_DEF = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BIT_CNT_W      = 3;
    localparam int unsigned COM_CNT_W      = 4;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic logic is_com(input logic [BYTE_W-1:0] b);
        return (b == COM_CHAR);
    endfunction

endpackage

// File: rtl/serial_a_paralelo_if.sv
// Serial input / parallel output bundle of the serial-to-parallel converter.
interface serial_a_paralelo_if;
    import serial_pkg::*;

    logic              data_in;
    logic [BYTE_W-1:0] data_out;
    logic              valid_out;
    logic              byte_strobe;
    logic              active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strobe,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strobe,
        output active
    );
endinterface

// File: rtl/serial_a_paralelo_sync.sv
// COM run counter and SEARCH/ACTIVE lock FSM, evaluated on byte boundaries.
module com_sync_counter
    import serial_pkg::*;
#(
    parameter int unsigned SYNC_COUNT = SYNC_COUNT_DEF
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic              byte_done,
    output logic              active
);

    localparam logic [COM_CNT_W-1:0] SYNC_TARGET = COM_CNT_W'(SYNC_COUNT);

    state_t               state;
    logic [COM_CNT_W-1:0] com_cnt;
    logic [COM_CNT_W-1:0] com_cnt_inc;

    assign com_cnt_inc = com_cnt + COM_CNT_W'(1);
    assign active      = (state == ACTIVE);

    // Count consecutive COM bytes while searching; lock once the run is long enough.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state   <= SEARCH;
            com_cnt <= '0;
        end else if (byte_done && state == SEARCH) begin
            if (is_com(rx_byte)) begin
                com_cnt <= com_cnt_inc;
                if (com_cnt_inc == SYNC_TARGET)
                    state <= ACTIVE;
            end else begin
                com_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/serial_a_paralelo.sv
// MSB-first serial-to-parallel converter with COM-run lock detection.
module serial_a_paralelo
    import serial_pkg::*;
#(
    parameter int unsigned SYNC_COUNT = SYNC_COUNT_DEF
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    serial_a_paralelo_if.slave bus
);

    logic [BYTE_W-1:0]    sr;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 byte_done;
    logic [BYTE_W-1:0]    rx_byte;
    logic                 active;
    logic [BYTE_W-1:0]    data_q;
    logic                 valid_q;
    logic                 strobe_q;

    assign byte_done = (bit_cnt == BIT_CNT_W'(BYTE_W - 1));
    assign rx_byte   = {sr[BYTE_W-2:0], bus.data_in};

    // Shift in one bit per clock; framing is fixed by reset release.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            sr      <= rx_byte;
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
    end

    com_sync_counter #(
        .SYNC_COUNT(SYNC_COUNT)
    ) u_sync (
        .clk_32f  (clk_32f),
        .reset_L  (reset_L),
        .rx_byte  (rx_byte),
        .byte_done(byte_done),
        .active   (active)
    );

    // Output byte and valid flag; uses the pre-edge lock state so the locking COM stays invalid.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= byte_done;
            if (byte_done) begin
                if (active && !is_com(rx_byte)) begin
                    data_q  <= rx_byte;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.data_out    = data_q;
    assign bus.valid_out   = valid_q;
    assign bus.byte_strobe = strobe_q;
    assign bus.active      = active;

endmodule

// File: doc/serial_a_paralelo.md
# serial_a_paralelo

Receive-side serial-to-parallel converter at the head of the receive path. It assembles MSB-first serial bits into bytes on the bit-rate clock and locks onto the link after a run of consecutive COM (0xBC) characters. Once locked, it delivers data bytes with a valid flag and a one-cycle byte strobe. It feeds the 1-to-2 lane demux stage, which in turn feeds the 2-to-4 L1 demux.

## Interface
- `COM`, 8'hBC: idle/comma character used for alignment and idle fill.
- `SYNC_COUNT`, 4: number of consecutive COM bytes required to assert `active`; legal range 1..15.
- `clk_32f` input 1: bit-rate clock; all logic is on the rising edge.
- `reset_L` input 1: asynchronous, active-low reset.
- `data_in` input 1: serial bit, MSB first, sampled on the rising edge of `clk_32f`.
- `data_out` output 8: last accepted data byte.
- `valid_out` output 1: `data_out` holds a non-COM byte received while `active`.
- `byte_strobe` output 1: one-cycle pulse each time a byte boundary completes.
- `active` output 1: link locked.

## Operation
- Reset (`reset_L`=0, asynchronous):
  - `data_out`=8'h00, `valid_out`=0, `byte_strobe`=0, `active`=0.
  - Shift register = 0, `bit_cnt` = 0, `com_cnt` = 0.
- Byte framing:
  - `bit_cnt` (3 bits) counts 0..7 and wraps, starting from 0 on the first edge after reset release.
  - Shift: `sr <= {sr[6:0], data_in}`.
  - The byte is complete when `bit_cnt`==7. The assembled byte is `{sr[6:0], data_in}` on that edge.
  - Alignment is fixed by reset release. There is no bit slipping.
- State machine, two states: SEARCH (reset state) and ACTIVE. Evaluated only on byte-complete edges.
  - SEARCH, byte==COM: `com_cnt`+1. If the new count equals `SYNC_COUNT`, go to ACTIVE and set `active`=1.
  - SEARCH, byte!=COM: `com_cnt`=0. `valid_out` stays 0. `data_out` is unchanged.
  - ACTIVE, byte==COM: `valid_out`=0. `data_out` is unchanged.
  - ACTIVE, byte!=COM: `data_out`=byte, `valid_out`=1.
  - ACTIVE is left only by reset. `com_cnt` is frozen in ACTIVE.
- `byte_strobe`=1 for exactly the cycle after every byte-complete edge, in both states.
- `valid_out` and `data_out` change only on byte-complete edges.

## Timing
- Latency: the last bit of a byte is sampled at edge N. `data_out`, `valid_out`, `active` and `byte_strobe` are all visible after edge N.
- `byte_strobe` period is exactly 8 clocks, with a 1-of-8 duty cycle.
- `active` rises after the edge that completes the `SYNC_COUNT`-th consecutive COM byte. With `SYNC_COUNT`=4, that is edge 32 after reset release (counting the first edge as 1).
- The locking COM byte itself produces `valid_out`=0.
- The first data byte after lock is valid 8 edges later, at the earliest.
- A non-COM byte between COM bytes in SEARCH restarts the count. The following COM counts as 1.
- Reset asserted mid-byte clears everything immediately. The partial byte is discarded and no strobe is produced.

## Structure
- Shared package `serial_pkg`: `COM_CHAR` (8'hBC), `SYNC_COUNT_DEF` (4), `BYTE_W` (8), `BIT_CNT_W` (3), and the state enum {SEARCH, ACTIVE}.
- Sub-module `com_sync_counter`:
  - Inputs: byte, byte-complete, clock/reset.
  - Outputs: `active`.
  - Contains `com_cnt` and the SEARCH/ACTIVE FSM.
- Shift register, `bit_cnt` and output registers stay in the top module.

## Test plan
- Reset, then hold `reset_L`=0 for 3 clocks with `data_in` toggling. Required: all outputs 0 and no strobe.
- Release reset, send 4×0xBC then 0x5A.
  - `active`=1 after edge 32.
  - `valid_out`=0 through edge 32.
  - After edge 40: `data_out`=0x5A, `valid_out`=1.
- Send 0xBC, 0xBC, 0xBC, 0x11, 0xBC×4. Required: `active` stays 0 until after the 8th byte (edge 64); 0x11 never appears on `data_out`.
- After lock, send 0x10, 0xBC, 0x1F. Required, byte by byte:
  - 0x10: `data_out`=0x10, `valid_out`=1.
  - 0xBC: `valid_out`=0, `data_out` still 0x10.
  - 0x1F: `data_out`=0x1F, `valid_out`=1.
- Check `byte_strobe` over 10 bytes. Required: a pulse exactly every 8 clocks, 1 cycle wide, in both SEARCH and ACTIVE.
- Lock, send 0x77, then assert `reset_L` at bit 3 of the next byte. Required: outputs clear immediately, and relock requires 4 fresh COM bytes.
